// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: issues aligned 64-bit line reads and hands out
// 32-bit instructions over valid/ready. Optional halt-on-ECALL via FETCH_HALT_ON_ECALL_EN.
//
// state   | meaning
// IDLE    | waiting for start
// REQ     | line request on the memory port, held until granted
// WAIT    | request granted, waiting for the read data
// DELIVER | instruction at pc offered to the decoder
// HALT    | ECALL consumed; waits for redirect (FETCH_HALT_ON_ECALL_EN only)
module fetch_sequencer #(
  parameter int ADDRSZ  = 64,
  parameter int INSTRSZ = 32,
  parameter int BUSSZ   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDRSZ-1:0]  entry,
  input  logic               redirect,
  input  logic [ADDRSZ-1:0]  redirect_pc,
  output logic               mem_req,
  output logic [ADDRSZ-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [BUSSZ-1:0]   mem_rdata,
  output logic               instr_valid,
  output logic [INSTRSZ-1:0] instr,
  output logic [ADDRSZ-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
`ifdef FETCH_HALT_ON_ECALL_EN
    HALT    = 3'd4,
`endif
    DELIVER = 3'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDRSZ-1:0]   pc_q, pc_d;
  logic [ADDRSZ-1:0]   addr_q, addr_d;
  logic [BUSSZ-1:0]    line_q, line_d;
  logic                line_valid_q, line_valid_d;
  logic                kill_q, kill_d;
  logic                handshake;

  localparam logic [ADDRSZ-1:0] WORD_MASK = ~ADDRSZ'(3);
  localparam logic [ADDRSZ-1:0] LINE_MASK = ~ADDRSZ'(7);

  assign handshake = (state_q == DELIVER) && instr_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    line_d       = line_q;
    line_valid_d = line_valid_q;
    kill_d       = kill_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = entry & WORD_MASK;
          state_d = REQ;
        end
      end
      REQ: begin
        // A redirected request still has to complete; kill drops its response.
        if (redirect) begin
          pc_d   = redirect_pc & WORD_MASK;
          kill_d = 1'b1;
        end
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          pc_d = redirect_pc & WORD_MASK;
          if (mem_rvalid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (mem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            line_d       = mem_rdata;
            line_valid_d = 1'b1;
            state_d      = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (redirect) begin
          pc_d         = redirect_pc & WORD_MASK;
          line_valid_d = 1'b0;
          state_d      = REQ;
        end else if (handshake) begin
          pc_d = pc_q + ADDRSZ'(4);
`ifdef FETCH_HALT_ON_ECALL_EN
          if (instr == INSTRSZ'('h73)) begin
            line_valid_d = 1'b0;
            state_d      = HALT;
          end else
`endif
          if (pc_q[2]) begin
            line_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
      end
`ifdef FETCH_HALT_ON_ECALL_EN
      HALT: begin
        if (redirect) begin
          pc_d    = redirect_pc & WORD_MASK;
          state_d = REQ;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Latch the line address on entry to REQ so it stays put until granted.
    if (state_d == REQ && state_q != REQ) addr_d = pc_d & LINE_MASK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      addr_q       <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      kill_q       <= kill_d;
    end
  end

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = addr_q;
  assign instr_valid = (state_q == DELIVER);
  assign instr       = instr_valid ? (pc_q[2] ? line_q[2*INSTRSZ-1:INSTRSZ] : line_q[INSTRSZ-1:0])
                                   : '0;
  assign instr_pc    = pc_q;
  assign busy        = (state_q != IDLE);
`ifdef FETCH_HALT_ON_ECALL_EN
  assign halted      = (state_q == HALT);
`else
  assign halted      = 1'b0;
`endif

endmodule
